// File: rtl/axi_defs.sv
// AXI4 encodings shared by the instruction-side bridge.
// Word size, INCR burst, response codes and cache attributes.
package axi_defs;

    localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [3:0] AXI_CACHE_WB   = 4'b1111;
    localparam logic [3:0] AXI_CACHE_UC   = 4'b0000;

endpackage

// File: rtl/inst_axi_rd_bridge.sv
// Fetch-side SRAM-like request port to single-beat AXI4 reads.
// One AR holding register, in-order returns, AR stall counter.
module inst_axi_rd_bridge
    import axi_defs::*;
#(
    parameter int         MAX_OUTSTANDING = 4,
    parameter logic [3:0] AXI_ID          = 4'd0,
    parameter int         CNT_W           = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic        inst_cache,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    output logic        inst_data_err,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [3:0]  arcache,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] perfcnt_ar_stall
);

    logic             r_arvalid;
    logic [31:0]      r_araddr;
    logic [3:0]       r_arcache;
    logic [CNT_W-1:0] r_outstanding;
    logic             r_data_ok;
    logic [31:0]      r_rdata;
    logic             r_data_err;
    logic [31:0]      r_ar_stall;

    logic w_slot_free;
    logic w_room;
    logic w_accept;
    logic w_rfire;
    logic w_unused_ok;

    assign w_slot_free = !r_arvalid || arready;
    assign w_room      = r_outstanding < CNT_W'(MAX_OUTSTANDING);
    assign w_accept    = inst_req && w_slot_free && w_room;
    assign w_rfire     = rvalid;
    // Single ID and single beat: rid/rlast carry no information here.
    assign w_unused_ok = ^{rid, rlast};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_arvalid     <= 1'b0;
            r_araddr      <= '0;
            r_arcache     <= AXI_CACHE_UC;
            r_outstanding <= '0;
            r_data_ok     <= 1'b0;
            r_rdata       <= '0;
            r_data_err    <= 1'b0;
            r_ar_stall    <= '0;
        end else begin
            if (w_accept) begin
                r_arvalid <= 1'b1;
                r_araddr  <= inst_addr;
                r_arcache <= inst_cache ? AXI_CACHE_WB : AXI_CACHE_UC;
            end else if (arready) begin
                r_arvalid <= 1'b0;
            end

            // A stray R beat with nothing in flight leaves the count at 0.
            if (w_accept && !w_rfire) begin
                r_outstanding <= r_outstanding + CNT_W'(1);
            end else if (!w_accept && w_rfire && r_outstanding != '0) begin
                r_outstanding <= r_outstanding - CNT_W'(1);
            end

            r_data_ok <= rvalid;
            if (rvalid) begin
                r_rdata    <= rdata;
                r_data_err <= rresp != AXI_RESP_OKAY;
            end

            if (r_arvalid && !arready) begin
                r_ar_stall <= r_ar_stall + 32'd1;
            end
        end
    end

    assign inst_addr_ok     = w_accept;
    assign inst_data_ok     = r_data_ok;
    assign inst_rdata       = r_rdata;
    assign inst_data_err    = r_data_err;
    assign arid             = AXI_ID;
    assign araddr           = r_araddr;
    assign arlen            = 8'd0;
    assign arsize           = AXI_SIZE_WORD;
    assign arburst          = AXI_BURST_INCR;
    assign arcache          = r_arcache;
    assign arvalid          = r_arvalid;
    assign rready           = 1'b1;
    assign perfcnt_ar_stall = r_ar_stall;

endmodule

// File: doc/inst_axi_rd_bridge.md
Name: inst_axi_rd_bridge

Overview:
- Responder end of the fetch-side SRAM-like instruction request interface: inst_req/inst_addr/inst_cache in, inst_addr_ok/inst_data_ok/inst_rdata out.
- Converts each accepted request into one single-beat AXI4 read. Returns the words in request order.
- Sits between the fetch/decode pipeline and the system AXI crossbar.
- Tracks up to MAX_OUTSTANDING in-flight reads. Provides a stall performance counter.

Parameters:
- MAX_OUTSTANDING, 4, maximum accepted-but-unreturned requests (1..15)
- AXI_ID, 4'd0, constant arid for all reads
- CNT_W, 4, outstanding counter width; must hold MAX_OUTSTANDING

Ports:
- clk  in  1  clock, all logic on posedge
- reset  in  1  synchronous, active-high reset
- inst_req  in  1  request valid from fetch
- inst_cache  in  1  1 = cacheable attribute
- inst_addr  in  32  physical word address
- inst_addr_ok  out  1  request accepted this cycle (combinational)
- inst_data_ok  out  1  returned word valid, one-cycle pulse
- inst_rdata  out  32  returned instruction word
- inst_data_err  out  1  rresp != OKAY for this returned word
- arid  out  4  = AXI_ID
- araddr  out  32  read address
- arlen  out  8  constant 0
- arsize  out  3  constant 3'b010
- arburst  out  2  constant 2'b01
- arcache  out  4  4'b1111 if cacheable, else 4'b0000
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- rid  in  4  ignored; in-order single ID
- rdata  in  32  read data
- rresp  in  2  read response
- rlast  in  1  ignored; always single beat
- rvalid  in  1  R valid
- rready  out  1  constant 1; the fetch side cannot back-pressure returns
- perfcnt_ar_stall  out  32  cycles with arvalid && !arready

Behaviour:
- Reset values: arvalid=0, araddr=0, arcache=0, outstanding=0, inst_data_ok=0, inst_rdata=0, inst_data_err=0, perfcnt_ar_stall=0.
- AR slot is one holding register; it is free when !arvalid || arready.
- inst_addr_ok = inst_req && slot_free && (outstanding < MAX_OUTSTANDING). Combinational, with no dependency on inst_addr.
- Accept (inst_addr_ok): next cycle araddr <= inst_addr, arcache <= {4{inst_cache}}, arvalid <= 1. Earliest AR issue is 1 cycle after accept.
- arvalid clears on arready only if no accept occurs in the same cycle. Accept plus arready in the same cycle gives back-to-back AR with arvalid held at 1.
- While arvalid && !arready, araddr and arcache hold stable (AXI rule). No accept is possible in that state.
- outstanding: +1 on accept, -1 on rvalid&&rready, unchanged when both occur. It never exceeds MAX_OUTSTANDING.
- If rvalid arrives with outstanding==0 (protocol violation), the counter saturates at 0 and the data is still forwarded.
- Return path: inst_data_ok <= rvalid, inst_rdata <= rdata, inst_data_err <= (rresp != 2'b00). Latency is 1 cycle after the R handshake. inst_rdata holds its last value when inst_data_ok=0.
- Ordering: a single ID guarantees in-order return. The n-th inst_data_ok corresponds to the n-th inst_addr_ok.
- Cancellation: the bridge never drops responses. The consumer discards cancelled returns by counting them.
- perfcnt_ar_stall increments each cycle arvalid && !arready and wraps at 2^32.
- Reset mid-operation clears all state. The AXI slave must be reset in the same cycle; stray R beats after reset are forwarded and the counter stays 0.

Decomposition:
- Shared package axi_defs: AXI_SIZE_WORD=3'b010, AXI_BURST_INCR=2'b01, AXI_RESP_OKAY=2'b00, AXI_CACHE_WB=4'b1111, AXI_CACHE_UC=4'b0000.
- Single module; no sub-module is natural. The AR holding register and the counter stay inline.

Test Plan:
- Single read: inst_req=1, addr=0x1FC00000, cache=0; arready=1; R 3 cycles later with rdata=0x3C081234 -> addr_ok in cycle 0; araddr=0x1FC00000, arcache=0 in cycle 1; data_ok with rdata=0x3C081234 1 cycle after the R handshake.
- Back-to-back: inst_req held, addrs 0x1000/0x1004/0x1008, arready=1, R returns in order -> 3 consecutive addr_ok; 3 consecutive AR beats; data_ok order matches.
- Outstanding limit: MAX=4, arready=1, rvalid=0, 6 requests -> exactly 4 addr_ok. After one R beat, the 5th is accepted the same cycle the count drops.
- AR backpressure: arready=0 for 5 cycles after the first accept -> araddr stable; addr_ok=0; perfcnt_ar_stall=5; the second request is accepted in the cycle arready=1.
- Error response: rresp=2'b10 with rdata=0xDEADBEEF -> data_ok=1, inst_data_err=1, rdata=0xDEADBEEF. The next OKAY response clears inst_data_err.
- Reset during traffic: 2 outstanding, reset=1 for 1 cycle -> arvalid=0, inst_data_ok=0, counter=0. Next request is accepted normally.
